// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clkdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_e;

    localparam int CLKDIV_MIN_DIV = 2;

    // Divisors below the minimum would make the wrap compare degenerate.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div < 32'(CLKDIV_MIN_DIV)) ? 32'(CLKDIV_MIN_DIV) : div;
    endfunction

endpackage

// File: rtl/clkdiv_cfg_reg.sv
// Config handshake, single-entry pending register and the active divisor/high-time
// registers; the counter FSM decides when pending settings become active.
module clkdiv_cfg_reg
    import clkdiv_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int DIV_RESET  = 10,
    parameter int HIGH_RESET = 5
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_high,
    input  logic             apply,
    output logic             cfg_ready,
    output logic             pending,
    output logic [DIV_W-1:0] div_act,
    output logic [DIV_W-1:0] high_act
);

    logic             pend_q;
    logic [DIV_W-1:0] pend_div_q;
    logic [DIV_W-1:0] pend_high_q;
    logic [DIV_W-1:0] div_act_q;
    logic [DIV_W-1:0] high_act_q;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            pend_q      <= 1'b0;
            pend_div_q  <= '0;
            pend_high_q <= '0;
            div_act_q   <= DIV_W'(DIV_RESET);
            high_act_q  <= DIV_W'(HIGH_RESET);
        end else if (apply && pend_q) begin
            div_act_q  <= pend_div_q;
            high_act_q <= pend_high_q;
            pend_q     <= 1'b0;
        end else if (cfg_valid && !pend_q) begin
            // High time is kept raw: the unsigned compare already yields
            // constant-high for high >= div and constant-low for high == 0.
            pend_div_q  <= DIV_W'(clamp_div(32'(cfg_div)));
            pend_high_q <= cfg_high;
            pend_q      <= 1'b1;
        end
    end

    assign cfg_ready = !pend_q;
    assign pending   = pend_q;
    assign div_act   = div_act_q;
    assign high_act  = high_act_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Run-time programmable clock divider with glitch-free reconfiguration and graceful stop.
// Optional restart input sync_in is built in when CLKDIV_SYNC_EN is defined.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | halted, counter 0, clock_out/tick low
//   RUN     | counting 0..div_act-1 and wrapping while enable is high
//   STOP    | enable dropped; finish the current period, then IDLE
module prog_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int DIV_RESET  = 10,
    parameter int HIGH_RESET = 5
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_high,
    output logic             cfg_ready,
    output logic             clock_out,
    output logic             tick,
    output logic             running
`ifdef CLKDIV_SYNC_EN
    ,
    input  logic             sync_in
`endif
);

    state_e           state_q;
    logic [DIV_W-1:0] counter_q;
    logic [DIV_W-1:0] counter_d;
    logic             clk_out_q;
    logic             tick_q;
    logic             active;
    logic             wrap;
    logic             restart;
    logic             apply;
    logic             pending;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] high_act;

    assign active = (state_q != ST_IDLE);
    assign wrap   = (counter_q == (div_act - DIV_W'(1)));

`ifdef CLKDIV_SYNC_EN
    assign restart = active && sync_in;
`else
    assign restart = 1'b0;
`endif

    // Pending settings land only on a period boundary so no runt pulse is produced.
    assign apply     = pending && (!active || wrap || restart);
    assign counter_d = (wrap || restart) ? '0 : counter_q + DIV_W'(1);

    clkdiv_cfg_reg #(
        .DIV_W      (DIV_W),
        .DIV_RESET  (DIV_RESET),
        .HIGH_RESET (HIGH_RESET)
    ) u_cfg (
        .clock_in  (clock_in),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .apply     (apply),
        .cfg_ready (cfg_ready),
        .pending   (pending),
        .div_act   (div_act),
        .high_act  (high_act)
    );

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    counter_q <= '0;
                    clk_out_q <= 1'b0;
                    tick_q    <= 1'b0;
                    if (enable) state_q <= ST_RUN;
                end
                default: begin
                    counter_q <= counter_d;
                    clk_out_q <= (counter_q < high_act);
                    tick_q    <= wrap && !restart;
                    if (state_q == ST_RUN) begin
                        if (!enable) state_q <= ST_STOP;
                    end else if (enable) begin
                        state_q <= ST_RUN;
                    end else if (wrap && !restart) begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign clock_out = clk_out_q;
    assign tick      = tick_q;
    assign running   = active;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench for prog_clock_divider: directed test-plan scenarios followed by
// randomized traffic, each cycle checked against a behavioural period model.
module tb_prog_clock_divider;

    logic        clock_in = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_div = '0;
    logic [15:0] cfg_high = '0;
    logic        cfg_ready;
    logic        clock_out;
    logic        tick;
    logic        running;
`ifdef CLKDIV_SYNC_EN
    logic        sync_in = 1'b0;
    localparam bit SYNC_BUILT = 1'b1;
`else
    localparam bit SYNC_BUILT = 1'b0;
`endif

    int total = 0;
    int bad = 0;

    always #5 clock_in = ~clock_in;

    prog_clock_divider #(.DIV_W(16), .DIV_RESET(10), .HIGH_RESET(5)) dut (
        .clock_in  (clock_in),
        .reset     (reset),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .cfg_ready (cfg_ready),
        .clock_out (clock_out),
        .tick      (tick),
        .running   (running)
`ifdef CLKDIV_SYNC_EN
        , .sync_in (sync_in)
`endif
    );

    typedef struct packed {
        bit out;
        bit tck;
        bit run;
        bit rdy;
    } exp_t;

    exp_t sb[$];

    // Reference model: position within the current period plus the settings in force.
    bit m_run = 0, m_stopping = 0, m_pend = 0, m_out = 0, m_tick = 0;
    int m_pos = 0, m_div = 10, m_high = 5, m_pdiv = 0, m_phigh = 0;

    function automatic void model_edge(bit rst, bit en, bit v, int d, int h, bit s);
        bit had_pend, period_end, rs;
        if (rst) begin
            m_run = 0; m_stopping = 0; m_pend = 0; m_out = 0; m_tick = 0;
            m_pos = 0; m_div = 10; m_high = 5;
            return;
        end
        had_pend = m_pend;
        if (!m_run) begin
            m_out = 0; m_tick = 0; m_pos = 0;
            if (had_pend) begin m_div = m_pdiv; m_high = m_phigh; m_pend = 0; end
            if (en) begin m_run = 1; m_stopping = 0; end
        end else begin
            rs = SYNC_BUILT && s;
            period_end = (m_pos == m_div - 1);
            m_out  = (m_pos < m_high);
            m_tick = period_end && !rs;
            if (period_end || rs) begin
                m_pos = 0;
                if (had_pend) begin m_div = m_pdiv; m_high = m_phigh; m_pend = 0; end
            end else begin
                m_pos++;
            end
            if (!m_stopping) m_stopping = !en;
            else if (en) m_stopping = 0;
            else if (period_end && !rs) begin m_run = 0; m_stopping = 0; end
        end
        if (v && !had_pend) begin
            m_pend = 1; m_pdiv = (d < 2) ? 2 : d; m_phigh = h;
        end
    endfunction

    task automatic step(input bit rst, input bit en, input bit v,
                        input int d, input int h, input bit s);
        exp_t e;
        @(negedge clock_in);
        reset = rst; enable = en; cfg_valid = v;
        cfg_div = 16'(d); cfg_high = 16'(h);
`ifdef CLKDIV_SYNC_EN
        sync_in = s;
`endif
        model_edge(rst, en, v, d, h, s);
        e.out = m_out; e.tck = m_tick; e.run = m_run; e.rdy = !m_pend;
        sb.push_back(e);
    endtask

    task automatic run(input int n, input bit en);
        for (int i = 0; i < n; i++) step(0, en, 0, 0, 0, 0);
    endtask

    task automatic check(input string name, input bit got, input bit want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, got, want);
        end
    endtask

    always @(posedge clock_in) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("clock_out", clock_out, e.out);
            check("tick",      tick,      e.tck);
            check("running",   running,   e.run);
            check("cfg_ready", cfg_ready, e.rdy);
        end
    end

    initial begin
        repeat (3) step(1, 0, 0, 0, 0, 0);
        run(35, 1);

        for (int i = 0; i < 20 && m_pos != 4; i++) run(1, 1);
        step(0, 1, 1, 4, 1, 0);
        run(25, 1);

        step(0, 1, 1, 0, 7, 0);
        run(12, 1);
        step(0, 1, 1, 0, 0, 0);
        run(10, 1);
        step(0, 1, 1, 10, 5, 0);
        run(15, 1);

        for (int i = 0; i < 20 && m_pos != 3; i++) run(1, 1);
        run(8, 0);
        run(5, 1);
        for (int i = 0; i < 20 && m_pos != 3; i++) run(1, 1);
        run(15, 0);

        run(13, 1);
        step(0, 1, 1, 3, 1, 0);
        step(1, 1, 0, 0, 0, 0);
        run(25, 1);

        for (int i = 0; i < 20 && m_pos != 2; i++) run(1, 1);
        step(0, 1, 1, 6, 2, 0);
        for (int i = 0; i < 20 && m_pos != 6; i++) run(1, 1);
        step(0, 1, 0, 0, 0, 1);
        run(20, 1);

        begin
            bit en_r = 1;
            for (int i = 0; i < 2500; i++) begin
                if ($urandom_range(0, 39) == 0) en_r = !en_r;
                step($urandom_range(0, 499) == 0, en_r,
                     $urandom_range(0, 7) == 0,
                     int'($urandom_range(0, 12)), int'($urandom_range(0, 14)),
                     $urandom_range(0, 29) == 0);
            end
        end
        run(4, 0);

        @(posedge clock_in);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_clock_divider.md
# prog_clock_divider

Run-time programmable clock divider that produces a divided clock enable-style output, `clock_out`, from `clock_in`. The divisor and high time are loaded through a valid/ready handshake. New settings take effect only at a period boundary, so the output never has a runt pulse. Start and stop are clean: the output always completes its current period before halting. The block drives PLL reference, test, and LED clocks in the wrapper, replacing fixed-divisor dividers.

## Interface
- `DIV_W`, 16: width of divisor, high-time and counter.
- `DIV_RESET`, 10: active divisor after reset.
- `HIGH_RESET`, 5: active high time after reset.
- `clock_in` input 1: the single clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `enable` input 1: run request, level-sensitive.
- `cfg_valid` input 1: config offer.
- `cfg_div` input DIV_W: requested period, in `clock_in` cycles.
- `cfg_high` input DIV_W: requested high cycles per period.
- `cfg_ready` output 1: config can be accepted.
- `clock_out` output 1: divided clock, registered.
- `tick` output 1: one-cycle pulse marking the last cycle of each period, registered.
- `running` output 1: high when state is not IDLE.
- `sync_in` input 1: present only with `CLKDIV_SYNC_EN`.

## Operation
- **Handshake:** a transfer occurs when `cfg_valid && cfg_ready`. The accepted pair goes to a pending register and `cfg_ready` drops until the pending value has been applied. Data is sampled only on a transfer.
- **Clamping, at accept time:**
  - `div < 2` is stored as 2.
  - `high >= div` gives `clock_out` constantly high while running.
  - `high == 0` gives `clock_out` constantly low.
- **States:** IDLE, RUN, STOP.
  - IDLE: `counter = 0`, `clock_out = 0`, `tick = 0`. `enable == 1` moves to RUN on the next edge.
  - RUN: counter counts 0..`div_act-1` and then wraps. `enable == 0` moves to STOP.
  - STOP: counting continues until the wrap, then the state goes to IDLE with `counter = 0`. `enable == 1` in STOP returns to RUN without disturbing the counter.
- **Per edge in RUN/STOP:**
  - `counter <= wrap ? 0 : counter + 1`, where `wrap = (counter == div_act-1)`.
  - `clock_out <= (counter < high_act)`.
  - `tick <= wrap`.
  - When going from STOP to IDLE, the final `clock_out` low phase completes and `clock_out <= 0` thereafter.
- **Pending application:**
  - In RUN/STOP: pending is applied at a wrap edge, provided it was already pending before that cycle.
  - In IDLE: pending is applied on the edge after acceptance.
  - On application, `cfg_ready` returns to 1 on the same edge.
- **Arithmetic:** `counter` is DIV_W bits wide and compares are unsigned. Because `div_act >= 2`, the counter never overflows.

## Timing
- **Reset values:**
  - state IDLE, counter 0, `div_act = DIV_RESET`, `high_act = HIGH_RESET`, no pending.
  - `clock_out = 0`, `tick = 0`, `running = 0`, `cfg_ready = 1`.
- **Reset mid-operation:** reset wins over everything. Any pending config is discarded and the output drops to 0 on the next edge.
- **Start latency:** `enable` is sampled high at edge 0. RUN begins at edge 1, and `clock_out` first rises at edge 2.
- **Period and duty:** once running, the period is exactly `div_act` cycles with `high_act` high cycles. `tick` coincides with the final low cycle of `clock_out`, or the final cycle of the period if `high_act >= div_act`.
- **Simultaneous events:**
  - A config accepted on a wrap cycle is applied at the following wrap.
  - When `enable` drops on a wrap cycle, the state enters STOP and runs one more full period.

## Configuration
- **`CLKDIV_SYNC_EN` defined:** adds the `sync_in` port. In RUN/STOP, `sync_in == 1` forces a restart:
  - `counter <= 0`, `tick <= 0`, and any pending config is applied.
  - `clock_out` follows the normal rule for that edge.
  - If `sync_in` and wrap occur together, the result is the same as the restart.
  - `sync_in` is ignored in IDLE.
- **`CLKDIV_SYNC_EN` undefined:** no `sync_in` port and no restart logic.

## Structure
- **Package `clkdiv_pkg`:**
  - state enum (IDLE/RUN/STOP)
  - minimum-divisor constant `CLKDIV_MIN_DIV = 2`
  - clamp function for div
- **Sub-module `clkdiv_cfg_reg`:** holds the handshake, the pending register, the active registers and clamping. It takes an `apply` strobe from the counter FSM.

## Test plan
- **Reset defaults:** after reset, raise `enable`. `clock_out` rises 2 cycles later and repeats 5 cycles high, 5 cycles low. `tick` pulses every 10 cycles.
- **Config load:** with `div=10` running, load `div=4`, `high=1` mid-period. The current 10-cycle period completes, then the output becomes a 1-high/3-low pattern. `cfg_ready` is low from accept until the wrap.
- **Clamping:** load `div=0`, `high=7`. The result is a period of 2 with the output constantly high. Load `high=0`: the output is constantly low while `tick` still pulses every 2 cycles.
- **Graceful stop:** drop `enable` at counter 3 with `div=10`. The period finishes, `running` falls after the wrap, and `clock_out` stays 0. Re-raising `enable` during STOP continues without a gap.
- **Reset mid-run:** assert `reset` while running with a pending config. All outputs return to their reset values and the next run uses `div 10`/`high 5`.
- **Sync restart (`CLKDIV_SYNC_EN` only):** pulse `sync_in` at counter 6 of 10. The counter is 0 the next cycle, a pending config is applied there, and no `tick` is asserted.
